// File: rtl/clint_pkg.sv
// clint_pkg: shared TileLink opcodes, CLINT register offsets and FSM state type
package clint_pkg;
    localparam logic [2:0] PUT_FULL = 3'd0;
    localparam logic [2:0] PUT_PARTIAL = 3'd1;
    localparam logic [2:0] GET = 3'd4;
    localparam logic [2:0] ACK = 3'd0;
    localparam logic [2:0] ACK_DATA = 3'd1;
    localparam logic [15:0] MSIP_OFF = 16'h0000;
    localparam logic [15:0] MTIMECMP_OFF = 16'h4000;
    localparam logic [15:0] MTIME_OFF = 16'hBFF8;
    typedef enum logic {IDLE, RESP} state_t;
    function automatic logic [63:0] byte_mask(input logic [7:0] m);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = {8{m[i]}};
        return r;
    endfunction
endpackage

// File: rtl/clint_timer_if.sv
// clint_timer_if: TileLink-UL A/D channel bundle between initiator and CLINT
interface clint_timer_if #(parameter int SRC_W = 4);
    logic a_valid;
    logic a_ready;
    logic [2:0] a_opcode;
    logic [2:0] a_size;
    logic [SRC_W-1:0] a_source;
    logic [63:0] a_address;
    logic [7:0] a_mask;
    logic [63:0] a_data;
    logic d_valid;
    logic d_ready;
    logic [2:0] d_opcode;
    logic [2:0] d_size;
    logic [SRC_W-1:0] d_source;
    logic d_denied;
    logic [63:0] d_data;
    modport master (
        output a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        input a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );
    modport slave (
        input a_valid, a_opcode, a_size, a_source, a_address, a_mask, a_data, d_ready,
        output a_ready, d_valid, d_opcode, d_size, d_source, d_denied, d_data
    );
endinterface

// File: rtl/tl_ul_slave_fsm.sv
// tl_ul_slave_fsm: single-outstanding A/D handshake; latches the response and holds it until d_ready
module tl_ul_slave_fsm import clint_pkg::*; #(
    parameter int SRC_W = 4
) (
    input logic clk,
    input logic rst,
    clint_timer_if.slave bus,
    input logic [2:0] rsp_opcode,
    input logic rsp_denied,
    input logic [63:0] rsp_data,
    output logic req_fire
);
    state_t state;
    assign req_fire = state == IDLE && bus.a_ready && bus.a_valid;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            bus.a_ready <= 1'b0;
            bus.d_valid <= 1'b0;
            bus.d_opcode <= 3'd0;
            bus.d_size <= 3'd0;
            bus.d_source <= '0;
            bus.d_denied <= 1'b0;
            bus.d_data <= 64'd0;
        end else if (state == IDLE) begin
            bus.a_ready <= !req_fire;
            if (req_fire) begin
                state <= RESP;
                bus.d_valid <= 1'b1;
                bus.d_opcode <= rsp_opcode;
                bus.d_size <= bus.a_size;
                bus.d_source <= bus.a_source[SRC_W-1:0];
                bus.d_denied <= rsp_denied;
                bus.d_data <= rsp_data;
            end
        end else if (bus.d_ready) begin
            state <= IDLE;
            bus.d_valid <= 1'b0;
            bus.a_ready <= 1'b1;
        end
    end
endmodule

// File: rtl/clint_timer.sv
// clint_timer: RISC-V CLINT (msip, mtimecmp, mtime) behind a TileLink-UL responder port
module clint_timer import clint_pkg::*; #(
    parameter logic [63:0] BASE_ADDR = 64'h0200_0000,
    parameter int TICK_DIV = 1,
    parameter int SRC_W = 4
) (
    input logic clk,
    input logic rst,
    clint_timer_if.slave bus,
    output logic timer_irq,
    output logic soft_irq
);
    localparam int TW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    logic [63:0] mtime, mtimecmp, cur, rdata, wbits;
    logic [31:0] half;
    logic [15:0] off;
    logic [TW-1:0] tick_cnt;
    logic msip, tick, in_win, is_get, is_put, size_ok, aligned, full_bad;
    logic sel_msip, sel_cmp, sel_time, denied, req_fire, wr;
    assign off = bus.a_address[15:0];
    assign in_win = bus.a_address[63:16] == BASE_ADDR[63:16];
    assign is_get = bus.a_opcode == GET;
    assign is_put = bus.a_opcode == PUT_FULL || bus.a_opcode == PUT_PARTIAL;
    assign size_ok = bus.a_size == 3'd2 || bus.a_size == 3'd3;
    assign aligned = bus.a_size == 3'd3 ? off[2:0] == 3'd0 : off[1:0] == 2'd0;
    assign full_bad = bus.a_opcode == PUT_FULL && bus.a_size == 3'd3 && bus.a_mask != 8'hFF;
    assign sel_msip = off[15:3] == MSIP_OFF[15:3];
    assign sel_cmp = off[15:3] == MTIMECMP_OFF[15:3];
    assign sel_time = off[15:3] == MTIME_OFF[15:3];
    assign denied = !(in_win && size_ok && aligned && (is_get || is_put) && (sel_msip || sel_cmp || sel_time)) || full_bad;
    assign cur = sel_msip ? {63'd0, msip} : sel_cmp ? mtimecmp : mtime;
    assign half = off[2] ? cur[63:32] : cur[31:0];
    assign rdata = bus.a_size == 3'd3 ? cur : {half, half};
    // 32-bit writes only touch the half selected by address bit 2
    assign wbits = byte_mask(bus.a_mask & (bus.a_size == 3'd3 ? 8'hFF : off[2] ? 8'hF0 : 8'h0F));
    assign wr = req_fire && is_put && !denied;
    assign tick = tick_cnt == TW'(TICK_DIV - 1);
    tl_ul_slave_fsm #(.SRC_W(SRC_W)) u_fsm (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .rsp_opcode(is_get ? ACK_DATA : ACK),
        .rsp_denied(denied),
        .rsp_data(denied || !is_get ? 64'd0 : rdata),
        .req_fire(req_fire)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            mtime <= 64'd0;
            mtimecmp <= '1;
            msip <= 1'b0;
            tick_cnt <= '0;
            timer_irq <= 1'b0;
            soft_irq <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
            mtime <= wr && sel_time ? (mtime & ~wbits) | (bus.a_data & wbits) : mtime + 64'(tick);
            if (wr && sel_cmp) mtimecmp <= (mtimecmp & ~wbits) | (bus.a_data & wbits);
            if (wr && sel_msip && wbits[0]) msip <= bus.a_data[0];
            timer_irq <= mtime >= mtimecmp;
            soft_irq <= msip;
        end
    end
endmodule

// File: tb/tb_clint_timer.sv
// tb_clint_timer: scenario tasks checked against a base+elapsed mtime model and byte-merge register model
module tb_clint_timer;
    import clint_pkg::*;
    localparam logic [63:0] BASE = 64'h0200_0000;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic timer_irq, soft_irq;
    int errors = 0;
    int checks = 0;
    longint unsigned cyc = 0;
    logic [63:0] m_base, m_cmp;
    longint unsigned m_edge;
    logic m_msip;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    clint_timer_if #(.SRC_W(4)) bus ();
    clint_timer #(.BASE_ADDR(BASE), .TICK_DIV(1), .SRC_W(4)) dut (
        .clk(clk), .rst(rst), .bus(bus), .timer_irq(timer_irq), .soft_irq(soft_irq)
    );

    // mtime after edge e: value last loaded plus one per elapsed clock
    function automatic logic [63:0] mtime_at(input longint unsigned e);
        return m_base + 64'(e - m_edge);
    endfunction

    function automatic logic [63:0] rd_view(input logic [63:0] v, input logic [2:0] sz, input logic hi);
        return sz == 3'd3 ? v : hi ? {v[63:32], v[63:32]} : {v[31:0], v[31:0]};
    endfunction

    task automatic model_reset();
        m_base = 64'd0;
        m_edge = cyc;
        m_cmp = '1;
        m_msip = 1'b0;
    endtask

    task automatic xact(input logic [2:0] op, input logic [2:0] sz, input logic [63:0] addr,
                        input logic [7:0] mask, input logic [63:0] data,
                        output logic [2:0] r_op, output logic r_den, output logic [63:0] r_data,
                        output longint unsigned acc, output logic irq_acc);
        int n = 0;
        bus.a_valid = 1'b1;
        bus.a_opcode = op;
        bus.a_size = sz;
        bus.a_source = 4'($urandom);
        bus.a_address = addr;
        bus.a_mask = mask;
        bus.a_data = data;
        while (!bus.a_ready && n < 20) begin @(negedge clk); n++; end
        acc = cyc + 1;
        @(negedge clk);
        bus.a_valid = 1'b0;
        irq_acc = timer_irq;
        n = 0;
        while (!bus.d_valid && n < 20) begin @(negedge clk); n++; end
        if (n == 20) begin
            checks++; errors++;
            $display("FAIL xact_timeout: d_valid never rose for addr %h", addr);
        end
        r_op = bus.d_opcode;
        r_den = bus.d_denied;
        r_data = bus.d_data;
        bus.d_ready = 1'b1;
        @(negedge clk);
        bus.d_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (bus.a_ready !== 1'b0) begin errors++; $display("FAIL reset_a_ready: got %b want 0", bus.a_ready); end
        checks++; if (bus.d_valid !== 1'b0) begin errors++; $display("FAIL reset_d_valid: got %b want 0", bus.d_valid); end
        checks++; if ({bus.d_denied, bus.d_opcode, bus.d_size, bus.d_source} !== 11'd0) begin errors++;
            $display("FAIL reset_d_fields: got %b %h %h %h want 0", bus.d_denied, bus.d_opcode, bus.d_size, bus.d_source); end
        checks++; if (bus.d_data !== 64'd0) begin errors++; $display("FAIL reset_d_data: got %h want 0", bus.d_data); end
        checks++; if ({timer_irq, soft_irq} !== 2'b00) begin errors++; $display("FAIL reset_irqs: got %b want 00", {timer_irq, soft_irq}); end
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        checks++; if (bus.a_ready !== 1'b1) begin errors++; $display("FAIL idle_a_ready: got %b want 1", bus.a_ready); end
    endtask

    task automatic test_mtime_read();
        logic [2:0] op; logic den, irq; logic [63:0] d; longint unsigned acc;
        repeat (10) @(negedge clk);
        xact(GET, 3'd3, BASE + 64'hBFF8, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (op !== ACK_DATA || den !== 1'b0) begin errors++; $display("FAIL mtime_get_resp: got op %0d den %b want 1 0", op, den); end
        checks++; if (d !== mtime_at(acc - 1)) begin errors++; $display("FAIL mtime_get_data: got %h want %h", d, mtime_at(acc - 1)); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL mtime_irq_idle: got %b want 0", timer_irq); end
        xact(GET, 3'd2, BASE + 64'hBFFC, 8'hF0, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== rd_view(mtime_at(acc - 1), 3'd2, 1'b1)) begin errors++; $display("FAIL mtime_get_hi: got %h want %h", d, rd_view(mtime_at(acc - 1), 3'd2, 1'b1)); end
        xact(GET, 3'd2, BASE + 64'hBFF8, 8'h0F, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== rd_view(mtime_at(acc - 1), 3'd2, 1'b0)) begin errors++; $display("FAIL mtime_get_lo: got %h want %h", d, rd_view(mtime_at(acc - 1), 3'd2, 1'b0)); end
    endtask

    task automatic test_timer_irq();
        logic [2:0] op; logic den, irq, exp; logic [63:0] d; longint unsigned acc;
        xact(PUT_FULL, 3'd3, BASE + 64'h4000, 8'hFF, 64'd20, op, den, d, acc, irq);
        m_cmp = 64'd20;
        checks++; if (op !== ACK || den !== 1'b0 || d !== 64'd0) begin errors++; $display("FAIL cmp_put_resp: got op %0d den %b data %h want 0 0 0", op, den, d); end
        xact(PUT_FULL, 3'd3, BASE + 64'hBFF8, 8'hFF, 64'd0, op, den, d, acc, irq);
        m_base = 64'd0;
        m_edge = acc;
        repeat (30) begin
            exp = mtime_at(cyc - 1) >= m_cmp;
            checks++; if (timer_irq !== exp) begin errors++; $display("FAIL irq_rise at cycle %0d: got %b want %b", cyc, timer_irq, exp); end
            @(negedge clk);
        end
        xact(PUT_FULL, 3'd3, BASE + 64'h4000, 8'hFF, '1, op, den, d, acc, irq);
        m_cmp = '1;
        checks++; if (irq !== 1'b1) begin errors++; $display("FAIL irq_before_drop: got %b want 1", irq); end
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL irq_drop: got %b want 0", timer_irq); end
    endtask

    task automatic test_msip();
        logic [2:0] op; logic den, irq; logic [63:0] d; longint unsigned acc;
        xact(PUT_PARTIAL, 3'd3, BASE, 8'h01, 64'd1, op, den, d, acc, irq);
        m_msip = 1'b1;
        checks++; if (op !== ACK || den !== 1'b0) begin errors++; $display("FAIL msip_put_resp: got op %0d den %b want 0 0", op, den); end
        checks++; if (soft_irq !== 1'b1) begin errors++; $display("FAIL soft_irq_set: got %b want 1", soft_irq); end
        xact(GET, 3'd3, BASE, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== 64'h1) begin errors++; $display("FAIL msip_get1: got %h want 1", d); end
        xact(GET, 3'd2, BASE + 64'h4, 8'hF0, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL msip_get_upper: got %h want 0", d); end
        xact(PUT_PARTIAL, 3'd3, BASE, 8'h01, 64'd0, op, den, d, acc, irq);
        m_msip = 1'b0;
        checks++; if (soft_irq !== 1'b0) begin errors++; $display("FAIL soft_irq_clr: got %b want 0", soft_irq); end
        xact(GET, 3'd3, BASE, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== 64'h0) begin errors++; $display("FAIL msip_get0: got %h want 0", d); end
    endtask

    task automatic test_errors();
        logic [2:0] op; logic den, irq; logic [63:0] d; longint unsigned acc;
        logic [2:0] e_op [6];
        logic [2:0] e_sz [6];
        logic [63:0] e_addr [6];
        logic [7:0] e_mask [6];
        e_op = '{GET, PUT_FULL, GET, GET, 3'd2, PUT_FULL};
        e_sz = '{3'd3, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3};
        e_addr = '{BASE + 64'h1234, BASE + 64'h4000, BASE + 64'h1BFF8, BASE + 64'hBFFC, BASE + 64'h4000, BASE + 64'h4000};
        e_mask = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
        for (int i = 0; i < 6; i++) begin
            xact(e_op[i], e_sz[i], e_addr[i], e_mask[i], 64'h5, op, den, d, acc, irq);
            checks++;
            if (den !== 1'b1 || d !== 64'd0 || op !== (e_op[i] == GET ? ACK_DATA : ACK)) begin errors++;
                $display("FAIL denied_%0d: got den %b data %h op %0d want 1 0 %0d", i, den, d, op, e_op[i] == GET ? ACK_DATA : ACK); end
        end
        xact(GET, 3'd3, BASE + 64'h4000, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== m_cmp) begin errors++; $display("FAIL denied_no_write: got %h want %h", d, m_cmp); end
        checks++; if (soft_irq !== 1'b0) begin errors++; $display("FAIL denied_msip: got %b want 0", soft_irq); end
    endtask

    task automatic test_random_regs();
        logic [2:0] op, r_op, sz; logic den, irq, hi, wr; logic [63:0] d, data, v, addr; longint unsigned acc;
        logic [7:0] lane, mask; int t;
        for (int i = 0; i < 30; i++) begin
            t = $urandom_range(0, 2);
            wr = t != 2 && $urandom_range(0, 1) == 1;
            sz = $urandom_range(0, 1) == 1 ? 3'd3 : 3'd2;
            hi = sz == 3'd2 && $urandom_range(0, 1) == 1;
            lane = sz == 3'd3 ? 8'hFF : hi ? 8'hF0 : 8'h0F;
            op = !wr ? GET : $urandom_range(0, 1) == 1 ? PUT_FULL : PUT_PARTIAL;
            mask = op == PUT_PARTIAL ? 8'($urandom) & lane : lane;
            data = {$urandom, $urandom};
            addr = BASE + (t == 0 ? 64'h0 : t == 1 ? 64'h4000 : 64'hBFF8) + (hi ? 64'h4 : 64'h0);
            xact(op, sz, addr, mask, data, r_op, den, d, acc, irq);
            if (wr) begin
                for (int b = 0; b < 8; b++) if (mask[b]) begin
                    if (t == 1) m_cmp[8*b +: 8] = data[8*b +: 8];
                    else if (b == 0) m_msip = data[0];
                end
                checks++; if (r_op !== ACK || den !== 1'b0 || d !== 64'd0) begin errors++;
                    $display("FAIL rand_put_%0d: got op %0d den %b data %h want 0 0 0", i, r_op, den, d); end
            end else begin
                v = t == 0 ? {63'd0, m_msip} : t == 1 ? m_cmp : mtime_at(acc - 1);
                checks++; if (r_op !== ACK_DATA || den !== 1'b0 || d !== rd_view(v, sz, hi)) begin errors++;
                    $display("FAIL rand_get_%0d: got op %0d den %b data %h want 1 0 %h", i, r_op, den, d, rd_view(v, sz, hi)); end
            end
        end
        xact(PUT_FULL, 3'd3, BASE + 64'h4000, 8'hFF, '1, r_op, den, d, acc, irq);
        m_cmp = '1;
        xact(PUT_FULL, 3'd3, BASE, 8'hFF, 64'd0, r_op, den, d, acc, irq);
        m_msip = 1'b0;
    endtask

    task automatic test_hold();
        logic [63:0] d0; longint unsigned acc; int n = 0;
        bus.a_valid = 1'b1; bus.a_opcode = GET; bus.a_size = 3'd3; bus.a_source = 4'h3;
        bus.a_address = BASE + 64'hBFF8; bus.a_mask = 8'hFF; bus.a_data = 64'd0;
        while (!bus.a_ready && n < 20) begin @(negedge clk); n++; end
        acc = cyc + 1;
        @(negedge clk);
        bus.a_opcode = PUT_FULL; bus.a_source = 4'hA; bus.a_address = BASE; bus.a_data = 64'd1;
        d0 = bus.d_data;
        checks++; if (d0 !== mtime_at(acc - 1)) begin errors++; $display("FAIL hold_first_data: got %h want %h", d0, mtime_at(acc - 1)); end
        repeat (5) begin
            checks++; if (bus.d_valid !== 1'b1 || bus.d_data !== d0 || bus.a_ready !== 1'b0 || bus.d_source !== 4'h3) begin errors++;
                $display("FAIL hold_stable: got d_valid %b data %h a_ready %b src %h want 1 %h 0 3", bus.d_valid, bus.d_data, bus.a_ready, bus.d_source, d0); end
            checks++; if (soft_irq !== 1'b0) begin errors++; $display("FAIL hold_no_second: got soft_irq %b want 0", soft_irq); end
            @(negedge clk);
        end
        bus.d_ready = 1'b1;
        @(negedge clk);
        bus.d_ready = 1'b0;
        checks++; if (bus.a_ready !== 1'b1 || bus.d_valid !== 1'b0) begin errors++;
            $display("FAIL hold_release: got a_ready %b d_valid %b want 1 0", bus.a_ready, bus.d_valid); end
        @(negedge clk);
        bus.a_valid = 1'b0;
        checks++; if (bus.d_valid !== 1'b1 || bus.d_opcode !== ACK || bus.d_source !== 4'hA) begin errors++;
            $display("FAIL hold_second_resp: got d_valid %b op %0d src %h want 1 0 a", bus.d_valid, bus.d_opcode, bus.d_source); end
        bus.d_ready = 1'b1;
        @(negedge clk);
        bus.d_ready = 1'b0;
        m_msip = 1'b1;
        checks++; if (soft_irq !== 1'b1) begin errors++; $display("FAIL hold_second_applied: got soft_irq %b want 1", soft_irq); end
    endtask

    task automatic test_mtime_wrap();
        logic [2:0] op; logic den, irq; logic [63:0] d; longint unsigned acc;
        xact(PUT_FULL, 3'd3, BASE + 64'hBFF8, 8'hFF, '1, op, den, d, acc, irq);
        m_base = '1;
        m_edge = acc;
        checks++; if (timer_irq !== 1'b1) begin errors++; $display("FAIL wrap_written_value: got timer_irq %b want 1", timer_irq); end
        @(negedge clk);
        checks++; if (timer_irq !== 1'b0) begin errors++; $display("FAIL wrap_to_zero: got timer_irq %b want 0", timer_irq); end
        xact(GET, 3'd3, BASE + 64'hBFF8, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== mtime_at(acc - 1)) begin errors++; $display("FAIL wrap_read: got %h want %h", d, mtime_at(acc - 1)); end
    endtask

    task automatic test_reset_in_resp();
        logic [2:0] op; logic den, irq; logic [63:0] d; longint unsigned acc; int n = 0;
        xact(PUT_FULL, 3'd3, BASE + 64'h4000, 8'hFF, 64'd5, op, den, d, acc, irq);
        bus.a_valid = 1'b1; bus.a_opcode = GET; bus.a_size = 3'd3; bus.a_source = 4'h1;
        bus.a_address = BASE + 64'hBFF8; bus.a_mask = 8'hFF;
        while (!bus.a_ready && n < 20) begin @(negedge clk); n++; end
        @(negedge clk);
        bus.a_valid = 1'b0;
        checks++; if (bus.d_valid !== 1'b1 || timer_irq !== 1'b1) begin errors++;
            $display("FAIL rst_resp_pre: got d_valid %b timer_irq %b want 1 1", bus.d_valid, timer_irq); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.d_valid !== 1'b0 || bus.a_ready !== 1'b0 || timer_irq !== 1'b0 || soft_irq !== 1'b0) begin errors++;
            $display("FAIL rst_resp_abandon: got d_valid %b a_ready %b irqs %b%b want 0 0 00", bus.d_valid, bus.a_ready, timer_irq, soft_irq); end
        rst = 1'b0;
        model_reset();
        xact(GET, 3'd3, BASE + 64'h4000, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== m_cmp) begin errors++; $display("FAIL rst_mtimecmp: got %h want %h", d, m_cmp); end
        xact(GET, 3'd3, BASE + 64'hBFF8, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== mtime_at(acc - 1)) begin errors++; $display("FAIL rst_mtime: got %h want %h", d, mtime_at(acc - 1)); end
        xact(GET, 3'd3, BASE, 8'hFF, 64'd0, op, den, d, acc, irq);
        checks++; if (d !== 64'd0) begin errors++; $display("FAIL rst_msip: got %h want 0", d); end
    endtask

    initial begin
        bus.a_valid = 1'b0; bus.a_opcode = 3'd0; bus.a_size = 3'd0; bus.a_source = 4'd0;
        bus.a_address = 64'd0; bus.a_mask = 8'd0; bus.a_data = 64'd0; bus.d_ready = 1'b0;
        test_reset();
        test_mtime_read();
        test_timer_irq();
        test_msip();
        test_errors();
        test_random_regs();
        test_hold();
        test_mtime_wrap();
        test_reset_in_resp();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end
endmodule
